// File: rtl/multiplier_datapath_tainttrack_if.sv
// Bundle between the shift-add multiplier control FSM and its taint-tracked datapath.
// Each data/control signal travels with its GLIFT taint shadow.
interface multiplier_datapath_tainttrack_if #(
   parameter int unsigned WIDTH = 4
);
   logic [WIDTH-1:0]   md_in;
   logic [WIDTH-1:0]   md_in_t;
   logic [WIDTH-1:0]   mr_in;
   logic [WIDTH-1:0]   mr_in_t;
   logic               rsload;
   logic               rsclear;
   logic               rsshr;
   logic               rsload_t;
   logic               rsclear_t;
   logic               rsshr_t;
   logic               mrld;
   logic               mdld;
   logic               mrld_t;
   logic               mdld_t;
   logic               done_in;
   logic               done_in_t;
   logic [WIDTH-1:0]   multiplierReg;
   logic [WIDTH-1:0]   multiplierReg_t;
   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] product_t;
   logic               product_valid;
   logic               product_valid_t;

   modport master (
      output md_in, md_in_t, mr_in, mr_in_t,
      output rsload, rsclear, rsshr, rsload_t, rsclear_t, rsshr_t,
      output mrld, mdld, mrld_t, mdld_t, done_in, done_in_t,
      input  multiplierReg, multiplierReg_t,
      input  product, product_t, product_valid, product_valid_t
   );

   modport slave (
      input  md_in, md_in_t, mr_in, mr_in_t,
      input  rsload, rsclear, rsshr, rsload_t, rsclear_t, rsshr_t,
      input  mrld, mdld, mrld_t, mdld_t, done_in, done_in_t,
      output multiplierReg, multiplierReg_t,
      output product, product_t, product_valid, product_valid_t
   );
endinterface

// File: rtl/multiplier_datapath_tainttrack.sv
// Shift-add multiplier datapath with a GLIFT taint shadow on every register.
// The result register rs is 2*WIDTH+1 bits; bit 2*WIDTH catches the add carry.
module multiplier_datapath_tainttrack #(
   parameter int unsigned WIDTH = 4
) (
   input logic                             clk,
   input logic                             rst,
   multiplier_datapath_tainttrack_if.slave bus
);
   localparam int unsigned RW = 2*WIDTH + 1;
   localparam int unsigned PW = 2*WIDTH;

   logic [WIDTH-1:0] md_q, md_d, md_t_q, md_t_d;
   logic [WIDTH-1:0] mr_q, mr_d, mr_t_q, mr_t_d;
   logic [RW-1:0]    rs_q, rs_d, rs_t_q, rs_t_d;
   logic [PW-1:0]    product_q, product_d, product_t_q, product_t_d;
   logic             pv_q, pv_d, pv_t_q, pv_t_d;

   logic [WIDTH:0]   sum_t;
   logic             acc_t;
   logic             ctl_t;

   always_comb begin
      md_d   = bus.mdld ? bus.md_in : md_q;
      md_t_d = (bus.mdld ? bus.md_in_t : md_t_q) | {WIDTH{bus.mdld_t}};
      mr_d   = bus.mrld ? bus.mr_in : mr_q;
      mr_t_d = (bus.mrld ? bus.mr_in_t : mr_t_q) | {WIDTH{bus.mrld_t}};
   end

   // Adder taint: a tainted input bit can ripple into every higher sum bit via carry.
   always_comb begin
      acc_t = 1'b0;
      sum_t = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         acc_t    = acc_t | rs_t_q[WIDTH+i] | md_t_q[i];
         sum_t[i] = acc_t;
      end
      sum_t[WIDTH] = sum_t[WIDTH-1];
   end

   always_comb begin
      rs_d   = rs_q;
      rs_t_d = rs_t_q;
      ctl_t  = bus.rsload_t | bus.rsclear_t | bus.rsshr_t;
      if (bus.rsclear) begin
         rs_d   = '0;
         rs_t_d = '0;
      end else if (bus.rsload) begin
         rs_d[2*WIDTH:WIDTH]   = {1'b0, rs_q[2*WIDTH-1:WIDTH]} + {1'b0, md_q};
         rs_t_d[2*WIDTH:WIDTH] = sum_t;
      end else if (bus.rsshr) begin
         rs_d   = {1'b0, rs_q[RW-1:1]};
         rs_t_d = {1'b0, rs_t_q[RW-1:1]};
      end
      // A tainted control could have selected any operation, so all of rs is tainted.
      rs_t_d = rs_t_d | {RW{ctl_t}};
   end

   always_comb begin
      product_d   = bus.done_in ? rs_d[PW-1:0] : product_q;
      product_t_d = (bus.done_in ? rs_t_d[PW-1:0] : product_t_q) | {PW{bus.done_in_t}};
      pv_d        = bus.done_in;
      pv_t_d      = bus.done_in_t;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         md_q        <= '0;
         md_t_q      <= '0;
         mr_q        <= '0;
         mr_t_q      <= '0;
         rs_q        <= '0;
         rs_t_q      <= '0;
         product_q   <= '0;
         product_t_q <= '0;
         pv_q        <= 1'b0;
         pv_t_q      <= 1'b0;
      end else begin
         md_q        <= md_d;
         md_t_q      <= md_t_d;
         mr_q        <= mr_d;
         mr_t_q      <= mr_t_d;
         rs_q        <= rs_d;
         rs_t_q      <= rs_t_d;
         product_q   <= product_d;
         product_t_q <= product_t_d;
         pv_q        <= pv_d;
         pv_t_q      <= pv_t_d;
      end
   end

   assign bus.multiplierReg   = mr_q;
   assign bus.multiplierReg_t = mr_t_q;
   assign bus.product         = product_q;
   assign bus.product_t       = product_t_q;
   assign bus.product_valid   = pv_q;
   assign bus.product_valid_t = pv_t_q;
endmodule

// File: tb/tb_multiplier_datapath_tainttrack.sv
// Scoreboard bench for the taint-tracked multiplier datapath: the bench plays the
// control FSM, queues expected products at done_in and checks them on product_valid.
module tb_multiplier_datapath_tainttrack;
   localparam int unsigned W = 4;

   typedef struct {
      logic [2*W-1:0] p;
      logic [2*W-1:0] pt;
      logic           pvt;
      int unsigned    cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   exp_t        exp_q[$];

   multiplier_datapath_tainttrack_if #(.WIDTH(W)) bus ();

   multiplier_datapath_tainttrack #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic clear_ctl();
      bus.rsload = 1'b0; bus.rsclear = 1'b0; bus.rsshr = 1'b0;
      bus.rsload_t = 1'b0; bus.rsclear_t = 1'b0; bus.rsshr_t = 1'b0;
      bus.mrld = 1'b0; bus.mdld = 1'b0; bus.mrld_t = 1'b0; bus.mdld_t = 1'b0;
      bus.done_in = 1'b0; bus.done_in_t = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      clear_ctl();
   endtask

   task automatic push(input logic [2*W-1:0] p, input logic [2*W-1:0] pt, input logic pvt);
      exp_t e;
      e.p = p; e.pt = pt; e.pvt = pvt; e.cyc = cyc + 1;
      exp_q.push_back(e);
   endtask

   // One full FSM sequence; taint_iter selects the iteration whose shift carries rsshr_t.
   task automatic run_mult(input logic [W-1:0] md, input logic [W-1:0] mdt,
                           input logic [W-1:0] mr, input logic [W-1:0] mrt,
                           input int taint_iter,
                           input logic [2*W-1:0] ep, input logic [2*W-1:0] ept, input logic epvt);
      bus.md_in = md; bus.md_in_t = mdt; bus.mr_in = mr; bus.mr_in_t = mrt;
      bus.mdld = 1'b1; bus.mrld = 1'b1; bus.rsclear = 1'b1;
      tick();
      check_eq("run_mr", 32'(bus.multiplierReg), 32'(mr));
      check_eq("run_mr_t", 32'(bus.multiplierReg_t), 32'(mrt));
      for (int i = 0; i < int'(W); i++) begin
         bus.rsshr = 1'b1;
         if (i == taint_iter) bus.rsshr_t = 1'b1;
         tick();
         if (mr[i]) begin
            bus.rsload = 1'b1;
            tick();
         end
      end
      bus.rsshr = 1'b1; bus.done_in = 1'b1;
      push(ep, ept, epvt);
      tick(); tick(); tick();
   endtask

   always @(negedge clk) begin
      if (bus.product_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_pulse", 32'(bus.product_valid), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq("product", 32'(bus.product), 32'(e.p));
            check_eq("product_t", 32'(bus.product_t), 32'(e.pt));
            check_eq("product_valid_t", 32'(bus.product_valid_t), 32'(e.pvt));
            check_eq("valid_latency", cyc, e.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish by 200000");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0]   m1, m2;
      logic [2*W-1:0] lastp;
      clear_ctl();
      bus.md_in = '0; bus.md_in_t = '0; bus.mr_in = '0; bus.mr_in_t = '0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check_eq("rst_mr", 32'(bus.multiplierReg), 32'd0);
      check_eq("rst_mr_t", 32'(bus.multiplierReg_t), 32'd0);
      check_eq("rst_product", 32'(bus.product), 32'd0);
      check_eq("rst_product_t", 32'(bus.product_t), 32'd0);
      check_eq("rst_pv", 32'(bus.product_valid), 32'd0);
      check_eq("rst_pv_t", 32'(bus.product_valid_t), 32'd0);

      bus.mrld = 1'b1; bus.mr_in = 4'hA; bus.mr_in_t = 4'h2;
      tick();
      check_eq("mrld_data", 32'(bus.multiplierReg), 32'hA);
      check_eq("mrld_taint", 32'(bus.multiplierReg_t), 32'h2);
      bus.mrld_t = 1'b1; bus.mr_in = 4'h5; bus.mr_in_t = 4'h0;
      tick();
      check_eq("mrld_t_hold", 32'(bus.multiplierReg), 32'hA);
      check_eq("mrld_t_taint", 32'(bus.multiplierReg_t), 32'hF);

      run_mult(4'd5, 4'h0, 4'd3, 4'h0, -1, 8'h0F, 8'h00, 1'b0);
      run_mult(4'd15, 4'h0, 4'd15, 4'h0, -1, 8'hE1, 8'h00, 1'b0);
      run_mult(4'd3, 4'b0001, 4'd1, 4'h0, -1, 8'h03, 8'h1F, 1'b0);
      run_mult(4'd5, 4'h0, 4'd3, 4'h0, 3, 8'h0F, 8'hFF, 1'b0);

      lastp = '0;
      for (int k = 0; k < 6; k++) begin
         m1 = W'($urandom_range(1, 15));
         m2 = W'($urandom_range(1, 15));
         lastp = {4'b0, m1} * {4'b0, m2};
         run_mult(m1, 4'h0, m2, 4'h0, -1, lastp, 8'h00, 1'b0);
      end

      // back-to-back done with rs holding
      bus.done_in = 1'b1; push(lastp, 8'h00, 1'b0); tick();
      bus.done_in = 1'b1; push(lastp, 8'h00, 1'b0); tick();
      tick(); tick();

      bus.done_in_t = 1'b1;
      tick();
      check_eq("dt_product", 32'(bus.product), 32'(lastp));
      check_eq("dt_product_t", 32'(bus.product_t), 32'hFF);
      check_eq("dt_pv", 32'(bus.product_valid), 32'd0);
      check_eq("dt_pv_t", 32'(bus.product_valid_t), 32'd1);
      tick();
      check_eq("dt_pv_t_drop", 32'(bus.product_valid_t), 32'd0);

      // reset mid-run, with done_in on the reset edge
      bus.md_in = 4'd7; bus.md_in_t = 4'h0; bus.mr_in = 4'd5; bus.mr_in_t = 4'h0;
      bus.mdld = 1'b1; bus.mrld = 1'b1; bus.rsclear = 1'b1; tick();
      bus.rsshr = 1'b1; tick();
      bus.rsload = 1'b1; tick();
      rst = 1'b1; bus.rsshr = 1'b1; bus.done_in = 1'b1; bus.rsshr_t = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("mid_rst_mr", 32'(bus.multiplierReg), 32'd0);
      check_eq("mid_rst_mr_t", 32'(bus.multiplierReg_t), 32'd0);
      check_eq("mid_rst_product", 32'(bus.product), 32'd0);
      check_eq("mid_rst_product_t", 32'(bus.product_t), 32'd0);
      check_eq("mid_rst_pv", 32'(bus.product_valid), 32'd0);
      check_eq("mid_rst_pv_t", 32'(bus.product_valid_t), 32'd0);
      tick();
      check_eq("post_rst_pv", 32'(bus.product_valid), 32'd0);
      bus.done_in = 1'b1; push(8'h00, 8'h00, 1'b0); tick();
      tick(); tick();

      // clear beats load on the same edge
      bus.md_in = 4'd5; bus.md_in_t = 4'h0; bus.mr_in = 4'd3; bus.mr_in_t = 4'h0;
      bus.mdld = 1'b1; bus.mrld = 1'b1; bus.rsclear = 1'b1; tick();
      bus.rsshr = 1'b1; tick();
      bus.rsload = 1'b1; tick();
      bus.rsclear = 1'b1; bus.rsload = 1'b1; tick();
      bus.rsshr = 1'b1; bus.done_in = 1'b1; push(8'h00, 8'h00, 1'b0); tick();
      tick(); tick();

      check_eq("pending_results", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/multiplier_datapath_tainttrack.md
Name: multiplier_datapath_tainttrack

Overview:
- Datapath for the shift-add sequential multiplier, with a GLIFT-style taint shadow on every register.
- Sits directly downstream of the multiplier control FSM. It consumes rsload/rsclear/rsshr/mrld/mdld and their taints.
- Returns the multiplier register and its taint to the FSM for bit tests.
- Captures the final product and its taint when the FSM signals done.

Parameters:
- WIDTH, 4, operand width; product is 2*WIDTH bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- md_in / md_in_t  in  WIDTH  multiplicand operand / per-bit taint
- mr_in / mr_in_t  in  WIDTH  multiplier operand / per-bit taint
- rsload, rsclear, rsshr  in  1 each  result-register controls from FSM
- rsload_t, rsclear_t, rsshr_t  in  1 each  control taints
- mrld, mdld  in  1 each  operand register loads
- mrld_t, mdld_t  in  1 each  load taints
- done_in / done_in_t  in  1  FSM productDone / taint
- multiplierReg / multiplierReg_t  out  WIDTH  multiplier register / taint, to FSM
- product / product_t  out  2*WIDTH  captured product / per-bit taint
- product_valid / product_valid_t  out  1  one-cycle pulse after capture / taint

Behaviour:
- Reset: rst is synchronous, active-high; clock clk. On rst, all registers and all taint shadows clear to 0: md, mr, rs (2*WIDTH+1 bits), product, product_valid. rst overrides every control, mid-operation included.
- md register: on mdld, md <= md_in. Taint: md_t <= (mdld ? md_in_t : md_t) | {WIDTH{mdld_t}}.
- mr register: same rule with mrld, mr_in, mr_in_t, mrld_t. Outputs multiplierReg = mr and multiplierReg_t = mr_t, both driven directly from registers.
- rs data update uses priority rsclear > rsload > rsshr; otherwise rs holds.
  - rsclear: rs <= 0.
  - rsload: rs[2W:W] <= {0,rs[2W-1:W]} + {0,md}, a (W+1)-bit sum where rs[2W] receives the carry; rs[W-1:0] holds.
  - rsshr: rs <= {0, rs[2W:1]}, a logical right shift by 1.
- rs taint is computed from the selected operation, then OR'd with {2W+1{rsload_t|rsclear_t|rsshr_t}}. A tainted control taints all of rs even when the control is deasserted.
  - clear: rs_t <= 0.
  - load: sum_t[i] = OR over j<=i of (rs_t[W+j] | md_t[j]) for i in 0..W-1. sum_t[W] = sum_t[W-1]. rs_t[2W:W] <= sum_t.
  - shift: rs_t <= {0, rs_t[2W:1]}.
  - hold: rs_t holds.
- Expected FSM sequence per operation: mdld+mrld+rsclear, then WIDTH iterations of rsshr optionally followed by rsload, then rsshr+done_in. After that sequence, rs[2W-1:0] holds md*mr. rs[2W] is 0 after every shift.
- Product capture:
  - On an edge with done_in=1: product <= next-rs[2W-1:0] (the value after that edge's rsshr), product_t <= next-rs_t[2W-1:0] | {2W{done_in_t}}.
  - product_valid <= 1 on the following cycle for exactly 1 cycle.
  - product_valid_t <= done_in_t, registered alongside product_valid.
  - done_in_t=1 with done_in=0: product_t is OR'd with all-ones and product_valid_t=1 next cycle; product data holds.
- product and product_t hold between captures. Back-to-back done_in produces consecutive pulses.
- Latency: the product is visible the cycle after done_in; product_valid is high in that same cycle.

Test Plan:
- W=4, md=5, mr=3, untainted, FSM sequence driven -> product=8'h0F, product_valid pulse 1 cycle after done_in, product_t=0, product_valid_t=0.
- md=15, mr=15 -> product=8'hE1 (carry through rs[8] exercised); multiplierReg=4'hF during run.
- md=3 with md_in_t=4'b0001, mr=1 untainted -> product=8'h03, product_t=8'h1F; multiplierReg_t=0.
- Untainted run with rsshr_t=1 for one mid-run cycle -> rs_t all ones from that edge, product_t=8'hFF, product_valid_t=0.
- rsclear and rsload asserted on the same edge with rs nonzero -> rs=0; rst asserted mid-run -> all outputs 0 next cycle and no product_valid pulse.
- mrld=1, mr_in=4'hA, mr_in_t=4'h2, mrld_t=0 -> multiplierReg=4'hA, multiplierReg_t=4'h2 next cycle. Then mrld=0, mrld_t=1 -> data holds, multiplierReg_t=4'hF.
